impulse_response_buffer: RTL and testbench
==========================================

# impulse_response_buffer

Upstream neighbour of the convolution engine. Captures a streamed impulse response (IR) of `IMPULSE_LENGTH` signed 16-bit samples and packs it into 8-sample rows in block RAM. Once the full IR is stored, it asserts `impulse_in_memory_complete`. After that it serves one 8-lane row per read request, so the convolver can fetch `ir_vals` by row index.

## Interface
- `IMPULSE_LENGTH`, default 24000: number of IR samples to capture.
- `LANES`, default 8: samples per row. This is fixed by the convolver and must equal the shared package constant.
- `ROWS`, derived as ceil(`IMPULSE_LENGTH`/`LANES`): 3000 at defaults.
- `audio_clk` input, 1 bit: the single clock. Reset is asynchronous and active-high.
- `rst_in` input, 1 bit: asynchronous, active-high reset.
- `load_start` input, 1 bit: single-cycle pulse that begins (or restarts) an IR capture.
- `ir_sample_in` input, signed 16 bits: incoming IR sample.
- `ir_sample_valid` input, 1 bit: qualifies `ir_sample_in` for one cycle.
- `impulse_in_memory_complete` output, 1 bit: level signal, high while a complete IR is stored.
- `rd_en` input, 1 bit: read request.
- `rd_row` input, 12 bits: row index to read; connects to the convolver's `first_ir_index`.
- `ir_vals` output, 8×16 bits (`logic signed [7:0][15:0]`): row data. `ir_vals[k]` holds sample `LANES*row + k`.
- `ir_vals_valid` output, 1 bit: single-cycle strobe marking `ir_vals` as updated.

## Operation
- FSM states and transitions:
  - `IDLE` → `LOADING` on `load_start`.
  - `LOADING` → `COMPLETE` once the last row is written.
  - `COMPLETE` → `LOADING` on `load_start`.
  - `LOADING` → `LOADING` on `load_start`: restart. Counters are cleared, stored rows are not erased, and `impulse_in_memory_complete` stays low.
- `impulse_in_memory_complete` is 1 only in `COMPLETE`.
- Capture in `LOADING`:
  - Each `ir_sample_valid` places the sample into lane `lane_cnt` of a row-assembly register, then increments `lane_cnt`.
  - When lane `LANES-1` is filled, the assembled row is written to RAM address `row_cnt`, `row_cnt` increments, `lane_cnt` wraps to 0 and the assembly register clears to 0.
- Final partial row: when sample `IMPULSE_LENGTH-1` arrives, the current row is written immediately and any unfilled lanes are zero. With defaults the length divides evenly, so no padding occurs.
- `ir_sample_valid` is ignored in `IDLE` and `COMPLETE`, and on the same cycle as `load_start`.
- Reads are served in every state, including mid-load. The requester is responsible for checking `impulse_in_memory_complete`.
- A read with `rd_row >= ROWS` returns all-zero lanes, still with `ir_vals_valid`.
- A read and a write to the same row in the same cycle return the old contents (read-first).
- No arithmetic is applied: samples are stored bit-exact.

## Timing
- Reset values of outputs: `impulse_in_memory_complete`=0, `ir_vals`=0, `ir_vals_valid`=0. FSM=`IDLE`, `lane_cnt`=0, `row_cnt`=0. RAM contents are not reset.
- Write latency: the RAM write happens on the cycle after the sample that completes a row.
- Completion: `impulse_in_memory_complete` rises 2 cycles after the valid cycle of the final sample, by which point the final row is committed.
- Read latency is 2 cycles, fully pipelined, with one request accepted per cycle:
  - `rd_en` at cycle t → RAM output at t+1 → registered `ir_vals` with `ir_vals_valid`=1 at t+2.
  - `ir_vals` holds its value when there is no new read.
- Sample rate: back-to-back `ir_sample_valid` (every cycle) must be accepted without loss.
- `load_start` takes effect on the next edge.
- Asynchronous reset mid-load returns to `IDLE` immediately. Any in-flight read strobe is dropped.

## Structure
- Shared package `aurras_audio_pkg` holds:
  - `IR_LANES` = 8;
  - `SAMPLE_W` = 16;
  - `typedef logic signed [IR_LANES-1:0][SAMPLE_W-1:0] ir_row_t`;
  - the FSM state enum `ir_buf_state_t`.
- One sub-module, `ir_row_ram`: a simple dual-port RAM (one write port, one read port), `ROWS` × 128 bits, read-first, with a registered output, inferable as BRAM.

## Test plan
- Capture and read-back: reset, pulse `load_start`, stream 24000 samples with value = index (one every cycle).
  - `impulse_in_memory_complete` rises exactly 2 cycles after the last valid.
  - Reading row 0 gives lanes 0..7.
  - Reading row 2999 gives lanes 23992..23999, with `ir_vals_valid` 2 cycles after `rd_en`.
- Partial row: `IMPULSE_LENGTH`=20, stream values 100..119.
  - Row 2 reads 116..119 in lanes 0..3 and 0 in lanes 4..7.
  - `impulse_in_memory_complete` asserts.
- Restart: load 5000 samples of 1000, pulse `load_start`, then load the full IR with value = -index.
  - `impulse_in_memory_complete` stays 0 until the second load finishes.
  - Row 1 then reads -8..-15.
- Out of range: reading row 3000 or 4095 returns all zeros with `ir_vals_valid`=1. Back-to-back reads of rows 0,1,2 produce three consecutive valid strobes carrying the correct data.
- Reset mid-load: assert `rst_in` after 100 samples.
  - All outputs are 0 at once.
  - Samples arriving afterwards without `load_start` are ignored and `row_cnt` stays 0.
  - A fresh load then completes normally.
- Ignored input: `ir_sample_valid` pulses while in `COMPLETE` do not alter the stored rows.

Source files
------------

// File: rtl/aurras_audio_pkg.sv
// Shared audio types: IR row layout and IR buffer FSM states.
// The convolver depends on IR_LANES, so it lives here and not in the buffer.
package aurras_audio_pkg;

  localparam int IR_LANES = 8;
  localparam int SAMPLE_W = 16;

  typedef logic signed [IR_LANES-1:0][SAMPLE_W-1:0] ir_row_t;

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    COMPLETE
  } ir_buf_state_t;

endpackage

// File: rtl/impulse_response_buffer_ram.sv
// Simple dual-port, read-first row RAM with registered output.
// Contents are not reset so the array maps onto block RAM.
module ir_row_ram
  import aurras_audio_pkg::*;
#(
  parameter int ROWS = 3000,
  parameter int AW   = 12
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [IR_LANES*SAMPLE_W-1:0]   wr_data,
  input  logic                           rd_en,
  input  logic [AW-1:0]                  rd_addr,
  output logic [IR_LANES*SAMPLE_W-1:0]   rd_data
);

  logic [IR_LANES*SAMPLE_W-1:0] mem [ROWS];
  logic [IR_LANES*SAMPLE_W-1:0] rd_data_q;

  // Non-blocking read of the old word gives read-first on address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/impulse_response_buffer.sv
// Captures a streamed impulse response into 8-lane RAM rows
// and serves one row per read request with 2-cycle latency.
module impulse_response_buffer
  import aurras_audio_pkg::*;
#(
  parameter int IMPULSE_LENGTH = 24000,
  parameter int LANES          = IR_LANES
) (
  input  logic                                      audio_clk,
  input  logic                                      rst_in,
  input  logic                                      load_start,
  input  logic signed [SAMPLE_W-1:0]                ir_sample_in,
  input  logic                                      ir_sample_valid,
  output logic                                      impulse_in_memory_complete,
  input  logic                                      rd_en,
  input  logic [11:0]                               rd_row,
  output logic signed [IR_LANES-1:0][SAMPLE_W-1:0]  ir_vals,
  output logic                                      ir_vals_valid
);

  localparam int ROWS = (IMPULSE_LENGTH + LANES - 1) / LANES;
  localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW   = $clog2(IR_LANES);
  localparam logic [AW+LW-1:0] LAST_IDX = (AW+LW)'(IMPULSE_LENGTH - 1);
  localparam logic [LW-1:0]    LAST_LANE = LW'(LANES - 1);

  ir_buf_state_t state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [AW-1:0] row_q, row_d;
  ir_row_t       asm_q, asm_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  ir_row_t       wr_data_q, wr_data_d;
  logic          last_q, last_d;
  logic          rd_v_q, rd_v_d;
  logic          oob_q, oob_d;
  ir_row_t       vals_q, vals_d;
  logic          vals_valid_q, vals_valid_d;

  logic    accept;
  logic    is_last;
  logic    in_range;
  ir_row_t ram_dout;
  ir_row_t row_nxt;

  assign in_range = 32'(rd_row) < ROWS;
  assign is_last  = {row_q, lane_q} == LAST_IDX;
  // last_q blocks capture during the one cycle before COMPLETE is entered.
  assign accept   = (state_q == LOADING) && ir_sample_valid
                    && !load_start && !last_q;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    row_d     = row_q;
    asm_d     = asm_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    row_nxt   = asm_q;
    row_nxt[lane_q] = ir_sample_in;
    unique case (1'b1)
      load_start: begin
        state_d = LOADING;
        lane_d  = '0;
        row_d   = '0;
        asm_d   = '0;
        last_d  = 1'b0;
      end
      accept: begin
        if (lane_q == LAST_LANE || is_last) begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_q;
          wr_data_d = row_nxt;
          asm_d     = '0;
          lane_d    = '0;
          row_d     = is_last ? '0 : row_q + 1'b1;
          last_d    = is_last;
        end else begin
          asm_d  = row_nxt;
          lane_d = lane_q + 1'b1;
        end
      end
      last_q: begin
        state_d = COMPLETE;
        last_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_v_d       = rd_en;
    oob_d        = rd_en && !in_range;
    vals_valid_d = rd_v_q;
    vals_d       = vals_q;
    if (rd_v_q) vals_d = oob_q ? '0 : ram_dout;
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      row_q        <= '0;
      asm_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_q       <= 1'b0;
      rd_v_q       <= 1'b0;
      oob_q        <= 1'b0;
      vals_q       <= '0;
      vals_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      row_q        <= row_d;
      asm_q        <= asm_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_q       <= last_d;
      rd_v_q       <= rd_v_d;
      oob_q        <= oob_d;
      vals_q       <= vals_d;
      vals_valid_q <= vals_valid_d;
    end
  end

  ir_row_ram #(
    .ROWS (ROWS),
    .AW   (AW)
  ) u_ram (
    .clk     (audio_clk),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_en   (rd_en && in_range),
    .rd_addr (rd_row[AW-1:0]),
    .rd_data (ram_dout)
  );

  assign impulse_in_memory_complete = (state_q == COMPLETE);
  assign ir_vals       = vals_q;
  assign ir_vals_valid = vals_valid_q;

endmodule

// File: tb/tb_impulse_response_buffer.sv
// Directed bench for impulse_response_buffer with a read scoreboard.
// A second instance with a 20-sample IR covers the padded last row.
module tb_impulse_response_buffer;
  import aurras_audio_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, load_start, smp_valid, rd_en;
  logic signed [15:0]   smp;
  logic [11:0]          rd_row;
  logic                 complete, vals_valid;
  ir_row_t              vals;

  logic                 p_load_start, p_smp_valid, p_rd_en;
  logic signed [15:0]   p_smp;
  logic [11:0]          p_rd_row;
  logic                 p_complete, p_vals_valid;
  ir_row_t              p_vals;

  impulse_response_buffer dut (
    .audio_clk                  (clk),
    .rst_in                     (rst),
    .load_start                 (load_start),
    .ir_sample_in               (smp),
    .ir_sample_valid            (smp_valid),
    .impulse_in_memory_complete (complete),
    .rd_en                      (rd_en),
    .rd_row                     (rd_row),
    .ir_vals                    (vals),
    .ir_vals_valid              (vals_valid)
  );

  impulse_response_buffer #(.IMPULSE_LENGTH(20)) dut_p (
    .audio_clk                  (clk),
    .rst_in                     (rst),
    .load_start                 (p_load_start),
    .ir_sample_in               (p_smp),
    .ir_sample_valid            (p_smp_valid),
    .impulse_in_memory_complete (p_complete),
    .rd_en                      (p_rd_en),
    .rd_row                     (p_rd_row),
    .ir_vals                    (p_vals),
    .ir_vals_valid              (p_vals_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic signed [15:0] model [24000];

  typedef struct {
    ir_row_t data;
    int      cyc;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, o, e);
    end
  endtask

  function automatic ir_row_t exp_row(input int r);
    ir_row_t x = '0;
    if (r < 3000)
      for (int k = 0; k < 8; k++) x[k] = model[8*r+k];
    return x;
  endfunction

  always @(negedge clk) begin
    if (vals_valid) begin
      exp_t e;
      e.data = '0;
      e.cyc  = -100;
      if (q.size() > 0) e = q.pop_front();
      chk("rd_data", vals, e.data);
      chk("rd_latency", 128'(cyc - e.cyc), 128'(2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int r);
    rd_en  = 1'b1;
    rd_row = r[11:0];
    q.push_back('{exp_row(r), cyc});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
    chk("rd_drain", 128'(q.size()), 128'(0));
  endtask

  task automatic load(input int n, input int mode);
    int v;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = (mode == 0) ? i : (mode == 1) ? 1000 :
          (mode == 2) ? -i : 5000 + i;
      smp       = 16'(v);
      smp_valid = 1'b1;
      model[i]  = smp;
      tick();
    end
    smp_valid = 1'b0;
  endtask

  task automatic junk(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      smp       = 16'(v);
      smp_valid = 1'b1;
      tick();
    end
    smp_valid = 1'b0;
  endtask

  initial begin
    ir_row_t pe;
    rst = 1'b1; load_start = 0; smp_valid = 0; smp = '0;
    rd_en = 0; rd_row = '0;
    p_load_start = 0; p_smp_valid = 0; p_smp = '0;
    p_rd_en = 0; p_rd_row = '0;
    for (int i = 0; i < 24000; i++) model[i] = '0;
    repeat (2) tick();
    chk("rst_complete", complete, 0);
    chk("rst_vals", vals, 0);
    chk("rst_valid", vals_valid, 0);
    rst = 1'b0;
    tick();

    load(24000, 0);
    chk("cmpl_early", complete, 0);
    tick();
    chk("cmpl_rise", complete, 1);
    rd(0);
    rd(2999);
    drain();
    chk("hold_vals", vals, exp_row(2999));
    chk("hold_valid", vals_valid, 0);

    junk(16, 12345);
    rd(0);
    rd(1);
    drain();
    chk("still_cmpl", complete, 1);

    rd(3000);
    rd(4095);
    rd(0);
    rd(1);
    rd(2);
    drain();

    p_load_start = 1'b1;
    tick();
    p_load_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      p_smp       = 16'(100 + i);
      p_smp_valid = 1'b1;
      tick();
    end
    p_smp_valid = 1'b0;
    chk("p_cmpl_early", p_complete, 0);
    tick();
    chk("p_cmpl_rise", p_complete, 1);
    p_rd_en  = 1'b1;
    p_rd_row = 12'd2;
    tick();
    p_rd_en = 1'b0;
    tick();
    pe = '0;
    for (int k = 0; k < 4; k++) pe[k] = 16'(116 + k);
    chk("p_row2_valid", p_vals_valid, 1);
    chk("p_row2", p_vals, pe);
    p_rd_en  = 1'b1;
    p_rd_row = 12'd0;
    tick();
    p_rd_en = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) pe[k] = 16'(100 + k);
    chk("p_row0", p_vals, pe);

    load(100, 3);
    rd(5);
    rst = 1'b1;
    #1;
    q.delete();
    chk("mid_rst_complete", complete, 0);
    chk("mid_rst_vals", vals, 0);
    chk("mid_rst_valid", vals_valid, 0);
    tick();
    tick();
    chk("mid_rst_drop", vals_valid, 0);
    rst = 1'b0;
    tick();
    junk(16, 7777);
    chk("idle_complete", complete, 0);
    rd(0);
    rd(1);
    drain();

    load(5000, 1);
    chk("restart_low", complete, 0);
    load(24000, 2);
    chk("restart_early", complete, 0);
    tick();
    chk("restart_rise", complete, 1);
    rd(1);
    rd(624);
    rd(2999);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
